// File: rtl/ctrl_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Multi-cycle control sequencer for the single-issue MIPS-subset
//            datapath. Walks each instruction through FETCH, LOAD_IR, DECODE,
//            EXEC, MEM, WB and NEXT, drives single-cycle load/read/write
//            strobes, reports halt/illegal status and counts retired
//            instructions.
// Params   : MEM_LAT    - I-cache / D-cache access cycles (1..15)
// Macro    : CTRL_ICOUNT_EN - when defined, implements the 32-bit retired
//            instruction counter; when undefined, icount is tied to 0.
// Ports    : clk, rst (async, active-high)
//            run        - permits start of a new fetch (sampled in IDLE/NEXT)
//            opcode     - IR[31:26], valid from DECODE onward
//            beq_taken  - branch comparator equal flag, sampled in EXEC
//            ic_read, ir_ld, rf_read, rf_write, dc_read, dc_write,
//            pc_incr, pc_ld - one-cycle strobes (at most one high per cycle)
//            wb_sel     - write-back source (0 = ALU, 1 = data cache)
//            state      - current state encoding
//            halted     - high in HALT
//            illegal    - sticky, an undefined opcode was decoded
//            icount     - retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        beq_taken,
  output logic        ic_read,
  output logic        ir_ld,
  output logic        rf_read,
  output logic        rf_write,
  output logic        wb_sel,
  output logic        dc_read,
  output logic        dc_write,
  output logic        pc_incr,
  output logic        pc_ld,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] icount
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_LOAD_IR = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC    = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_NEXT    = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_ADDI = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_HALT = 6'd63;

  // Wait counter counts down to zero; a load of LAT-1 gives LAT cycles.
  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       take_q, take_d;
  logic       illegal_q, illegal_d;
  logic       halted_q, halted_d;
  logic       ic_read_q, ic_read_d;
  logic       ir_ld_q, ir_ld_d;
  logic       rf_read_q, rf_read_d;
  logic       rf_write_q, rf_write_d;
  logic       wb_sel_q, wb_sel_d;
  logic       dc_read_q, dc_read_d;
  logic       dc_write_q, dc_write_d;
  logic       pc_incr_q, pc_incr_d;
  logic       pc_ld_q, pc_ld_d;

  logic       entering_fetch;
  logic       entering_mem;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    take_d    = take_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == 4'd0) state_d = S_LOAD_IR;
        else                wait_d  = wait_q - 4'd1;
      end
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:  state_d = S_NEXT;
          OP_HALT: state_d = S_HALT;
          OP_ADD, OP_SUB, OP_OR, OP_AND, OP_ADDI,
          OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        if (opcode == OP_BEQ) begin
          take_d  = beq_taken;
          state_d = S_NEXT;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (wait_q == 4'd0) state_d = (opcode == OP_LW) ? S_WB : S_NEXT;
        else                wait_d  = wait_q - 4'd1;
      end
      S_WB:   state_d = S_NEXT;
      S_NEXT: begin
        take_d  = 1'b0;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    entering_fetch = (state_d == S_FETCH) && (state_q != S_FETCH);
    entering_mem   = (state_d == S_MEM)   && (state_q != S_MEM);
    if (entering_fetch || entering_mem) wait_d = WAIT_RELOAD;

    // Strobes are decoded from the next state so that they come out of
    // flops aligned with the state they belong to.
    ic_read_d  = entering_fetch;
    ir_ld_d    = (state_d == S_LOAD_IR);
    rf_read_d  = (state_d == S_DECODE);
    rf_write_d = (state_d == S_WB);
    wb_sel_d   = (state_d == S_WB) && (opcode == OP_LW);
    dc_read_d  = entering_mem && (opcode == OP_LW);
    dc_write_d = entering_mem && (opcode == OP_SW);
    pc_ld_d    = (state_d == S_NEXT) && take_d;
    pc_incr_d  = (state_d == S_NEXT) && !take_d;
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      take_q     <= 1'b0;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
      ic_read_q  <= 1'b0;
      ir_ld_q    <= 1'b0;
      rf_read_q  <= 1'b0;
      rf_write_q <= 1'b0;
      wb_sel_q   <= 1'b0;
      dc_read_q  <= 1'b0;
      dc_write_q <= 1'b0;
      pc_incr_q  <= 1'b0;
      pc_ld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      take_q     <= take_d;
      illegal_q  <= illegal_d;
      halted_q   <= halted_d;
      ic_read_q  <= ic_read_d;
      ir_ld_q    <= ir_ld_d;
      rf_read_q  <= rf_read_d;
      rf_write_q <= rf_write_d;
      wb_sel_q   <= wb_sel_d;
      dc_read_q  <= dc_read_d;
      dc_write_q <= dc_write_d;
      pc_incr_q  <= pc_incr_d;
      pc_ld_q    <= pc_ld_d;
    end
  end

`ifdef CTRL_ICOUNT_EN
  logic [31:0] icount_q;

  // Retirement is counted as the NEXT cycle completes; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    icount_q <= 32'd0;
    else if (state_q == S_NEXT) icount_q <= icount_q + 32'd1;
  end

  assign icount = icount_q;
`else
  assign icount = 32'd0;
`endif

  assign state    = state_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign ic_read  = ic_read_q;
  assign ir_ld    = ir_ld_q;
  assign rf_read  = rf_read_q;
  assign rf_write = rf_write_q;
  assign wb_sel   = wb_sel_q;
  assign dc_read  = dc_read_q;
  assign dc_write = dc_write_q;
  assign pc_incr  = pc_incr_q;
  assign pc_ld    = pc_ld_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Purpose  : Self-checking bench for ctrl_sequencer. Two instances
//            (MEM_LAT = 1 and MEM_LAT = 3) are exercised one after the other
//            with random instruction streams; each instruction's expected
//            per-cycle trace is built from the opcode class rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_LOAD_IR = 4'd2,
                         ST_DECODE = 4'd3, ST_EXEC = 4'd4, ST_MEM = 4'd5,
                         ST_WB = 4'd6, ST_NEXT = 4'd7, ST_HALT = 4'd8;

  // Strobe bit positions: ic_read, ir_ld, rf_read, rf_write, dc_read,
  // dc_write, pc_incr, pc_ld (MSB to LSB).
  localparam logic [7:0] B_IC = 8'h80, B_IR = 8'h40, B_RF = 8'h20, B_RW = 8'h10,
                         B_DR = 8'h08, B_DW = 8'h04, B_PI = 8'h02, B_PL = 8'h01;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] stb;
    logic       wb;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_s [2];
  logic [5:0]  op_s  [2];
  logic        beq_s [2];
  logic        ic_read_s [2], ir_ld_s [2], rf_read_s [2], rf_write_s [2];
  logic        wb_sel_s [2], dc_read_s [2], dc_write_s [2];
  logic        pc_incr_s [2], pc_ld_s [2], halted_s [2], illegal_s [2];
  logic [3:0]  state_s [2];
  logic [31:0] icount_s [2];

  int   n_vec = 0;
  int   n_err = 0;
  int   retired [2];
  bit   idle_m [2];
  cyc_t exp_q [$];

  always #5 clk = ~clk;

  ctrl_sequencer #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .run(run_s[0]), .opcode(op_s[0]), .beq_taken(beq_s[0]),
    .ic_read(ic_read_s[0]), .ir_ld(ir_ld_s[0]), .rf_read(rf_read_s[0]),
    .rf_write(rf_write_s[0]), .wb_sel(wb_sel_s[0]), .dc_read(dc_read_s[0]),
    .dc_write(dc_write_s[0]), .pc_incr(pc_incr_s[0]), .pc_ld(pc_ld_s[0]),
    .state(state_s[0]), .halted(halted_s[0]), .illegal(illegal_s[0]),
    .icount(icount_s[0])
  );

  ctrl_sequencer #(.MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .run(run_s[1]), .opcode(op_s[1]), .beq_taken(beq_s[1]),
    .ic_read(ic_read_s[1]), .ir_ld(ir_ld_s[1]), .rf_read(rf_read_s[1]),
    .rf_write(rf_write_s[1]), .wb_sel(wb_sel_s[1]), .dc_read(dc_read_s[1]),
    .dc_write(dc_write_s[1]), .pc_incr(pc_incr_s[1]), .pc_ld(pc_ld_s[1]),
    .state(state_s[1]), .halted(halted_s[1]), .illegal(illegal_s[1]),
    .icount(icount_s[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // {state, strobes[7:0], wb_sel, halted, illegal}
  function automatic logic [14:0] obs_vec(input int d);
    return {state_s[d], ic_read_s[d], ir_ld_s[d], rf_read_s[d], rf_write_s[d],
            dc_read_s[d], dc_write_s[d], pc_incr_s[d], pc_ld_s[d],
            wb_sel_s[d], halted_s[d], illegal_s[d]};
  endfunction

  function automatic logic [31:0] exp_icount(input int d);
`ifdef CTRL_ICOUNT_EN
    return 32'(retired[d]);
`else
    return 32'd0;
`endif
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op <= 6'd8) || (op == 6'd63);
  endfunction

  task automatic push(input logic [3:0] st, input logic [7:0] stb, input logic wb);
    cyc_t c;
    c.st = st; c.stb = stb; c.wb = wb;
    exp_q.push_back(c);
  endtask

  // Expected trace of one instruction, starting at its first FETCH cycle.
  task automatic build(input int lat, input logic [5:0] op, input bit taken);
    exp_q.delete();
    push(ST_FETCH, B_IC, 1'b0);
    for (int i = 1; i < lat; i++) push(ST_FETCH, 8'h00, 1'b0);
    push(ST_LOAD_IR, B_IR, 1'b0);
    push(ST_DECODE, B_RF, 1'b0);
    if (op == 6'd0) begin
      push(ST_NEXT, B_PI, 1'b0);
    end else if (!is_legal(op) || op == 6'd63) begin
      push(ST_HALT, 8'h00, 1'b0);
    end else begin
      push(ST_EXEC, 8'h00, 1'b0);
      if (op == 6'd8) begin
        push(ST_NEXT, taken ? B_PL : B_PI, 1'b0);
      end else if (op == 6'd5 || op == 6'd6) begin
        push(ST_MEM, (op == 6'd5) ? B_DR : B_DW, 1'b0);
        for (int i = 1; i < lat; i++) push(ST_MEM, 8'h00, 1'b0);
        if (op == 6'd5) push(ST_WB, B_RW, 1'b1);
        push(ST_NEXT, B_PI, 1'b0);
      end else begin
        push(ST_WB, B_RW, 1'b0);
        push(ST_NEXT, B_PI, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_outputs", 64'(obs_vec(d)), 64'd0);
      check("reset_icount", 64'(icount_s[d]), 64'd0);
      retired[d] = 0;
      idle_m[d]  = 1'b1;
      run_s[d]   = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_instr(input int d, input logic [5:0] op, input bit taken, input bit run_next);
    int   lat;
    bit   ill;
    cyc_t e;
    lat = (d == 0) ? 1 : 3;
    ill = !is_legal(op);
    if (idle_m[d]) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check("idle_hold", 64'(obs_vec(d)), 64'({ST_IDLE, 8'h00, 3'b000}));
        check("idle_icount", 64'(icount_s[d]), 64'(exp_icount(d)));
        op_s[d]  = 6'($urandom);
        beq_s[d] = 1'($urandom);
      end
      run_s[d]  = 1'b1;
      idle_m[d] = 1'b0;
    end
    build(lat, op, taken);
    foreach (exp_q[k]) begin
      @(negedge clk);
      e = exp_q[k];
      check("cycle", 64'(obs_vec(d)),
            64'({e.st, e.stb, e.wb, (e.st == ST_HALT), (e.st == ST_HALT) && ill}));
      if (e.st != ST_NEXT) check("icount", 64'(icount_s[d]), 64'(exp_icount(d)));
      op_s[d]  = (e.st >= ST_LOAD_IR && e.st <= ST_WB) ? op : 6'($urandom);
      beq_s[d] = (e.st == ST_EXEC) ? taken : 1'($urandom);
      run_s[d] = (e.st == ST_NEXT) ? run_next : 1'($urandom);
    end
    if (exp_q[exp_q.size()-1].st == ST_HALT) begin
      repeat (20) begin
        @(negedge clk);
        check("halt_hold", 64'(obs_vec(d)), 64'({ST_HALT, 8'h00, 1'b0, 1'b1, ill}));
        check("halt_icount", 64'(icount_s[d]), 64'(exp_icount(d)));
        run_s[d] = 1'($urandom);
        op_s[d]  = 6'($urandom);
        beq_s[d] = 1'($urandom);
      end
    end else begin
      retired[d]++;
      idle_m[d] = !run_next;
    end
  endtask

  function automatic logic [5:0] rand_op();
    return 6'($urandom_range(0, 8));
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      run_s[d] = 1'b0; op_s[d] = 6'd0; beq_s[d] = 1'b0;
    end
    do_reset();

    // MEM_LAT = 1 instance
    do_instr(0, 6'd1, 1'b0, 1'b1);
    do_instr(0, 6'd8, 1'b1, 1'b1);
    do_instr(0, 6'd8, 1'b0, 1'b1);
    do_instr(0, 6'd1, 1'b0, 1'b0);
    repeat (40) do_instr(0, rand_op(), 1'($urandom), $urandom_range(0, 3) != 0);
    do_instr(0, 6'd63, 1'b0, 1'b1);
    do_reset();
    do_instr(0, 6'd9, 1'b0, 1'b1);
    do_reset();
    do_instr(0, 6'($urandom_range(10, 62)), 1'b0, 1'b1);
    do_reset();

    // MEM_LAT = 3 instance
    do_instr(1, 6'd5, 1'b0, 1'b1);
    do_instr(1, 6'd6, 1'b0, 1'b1);
    repeat (40) do_instr(1, rand_op(), 1'($urandom), $urandom_range(0, 3) != 0);
    do_instr(1, 6'd63, 1'b0, 1'b1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer for the single-issue MIPS-subset datapath. It sits directly upstream of the PC, instruction cache, IR, register file, ALU/branch comparator and data cache, and drives their edge-sensitive load/read/write strobes. It walks each instruction through fetch, IR load, decode, execute, memory, write-back and PC update. It also raises halt and illegal-opcode status and counts retired instructions.

## Interface
- `MEM_LAT`, default 1: cycles allowed for an instruction-cache or data-cache access; legal range 1–15.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; permits the start of a new instruction fetch.
- `opcode`  in  6  IR[31:26], valid from the DECODE cycle onward.
- `beq_taken`  in  1  branch-comparator equal flag, sampled in EXEC.
- `ic_read`  out  1  instruction-cache read strobe.
- `ir_ld`  out  1  IR load strobe.
- `rf_read`  out  1  register-file read strobe.
- `rf_write`  out  1  register-file write strobe.
- `wb_sel`  out  1  write-back source: 0 = ALU, 1 = data cache.
- `dc_read`  out  1  data-cache read strobe.
- `dc_write`  out  1  data-cache write strobe.
- `pc_incr`  out  1  PC increment strobe.
- `pc_ld`  out  1  PC load strobe (branch target).
- `state`  out  4  current state encoding.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky flag: an undefined opcode was decoded.
- `icount`  out  32  retired-instruction count.

## Operation
- Opcodes: 0 nop; 1 add; 2 sub; 3 or; 4 and; 5 lw; 6 sw; 7 addi; 8 beq; 63 halt. Any other value is illegal.
- State encodings: IDLE=0, FETCH=1, LOAD_IR=2, DECODE=3, EXEC=4, MEM=5, WB=6, NEXT=7, HALT=8.
- IDLE: if `run`=1, go to FETCH; otherwise stay.
- FETCH: `ic_read` is high in the first cycle only. Stay MEM_LAT cycles, then go to LOAD_IR.
- LOAD_IR: `ir_ld` high for 1 cycle, then DECODE.
- DECODE: `rf_read` high for 1 cycle.
  - nop goes to NEXT.
  - halt goes to HALT.
  - An illegal opcode sets `illegal` and goes to HALT.
  - All other opcodes go to EXEC.
- EXEC: no strobes; 1 cycle.
  - beq latches `beq_taken` into an internal take flag, then goes to NEXT.
  - lw and sw go to MEM.
  - ALU ops (1–4, 7) go to WB.
- MEM: `dc_read` (lw) or `dc_write` (sw) is high in the first cycle only. Stay MEM_LAT cycles. lw then goes to WB; sw goes to NEXT.
- WB: `rf_write` high for 1 cycle. `wb_sel`=1 for lw and 0 otherwise; it is held stable throughout WB. Then NEXT.
- NEXT: `pc_ld` is high if the take flag is set, otherwise `pc_incr` is high. Never both. The take flag clears.
  - `icount` increments by 1 and wraps from 0xFFFFFFFF to 0.
  - Go to FETCH if `run`=1, else IDLE.
- HALT: terminal. `halted`=1, all strobes stay 0, `icount` is frozen. Exit only via `rst`.
- The wait counter is 4 bits and is reloaded on entry to FETCH and to MEM.

## Timing
- All outputs are registered, and every strobe is a single-cycle pulse from 0 to 1 to 0. Downstream blocks act on its rising edge.
- At most one of `ic_read`, `ir_ld`, `rf_read`, `rf_write`, `dc_read`, `dc_write`, `pc_incr`, `pc_ld` is high in any cycle.
- Cycles per instruction, with L = MEM_LAT:
  - nop: 3+L
  - beq: 4+L
  - ALU op: 5+L
  - sw: 4+2L
  - lw: 5+2L
- `run` is sampled only in IDLE and NEXT. Deasserting `run` mid-instruction lets that instruction complete.
- Reset values on `rst`=1, applied immediately and asynchronously:
  - `state`=IDLE.
  - All strobes = 0, `wb_sel`=0.
  - `halted`=0, `illegal`=0, `icount`=0, take flag = 0.
- Reset mid-instruction abandons it without a PC update.
- The first fetch occurs 1 cycle after `rst` falls with `run` high.

## Configuration
- `CTRL_ICOUNT_EN`:
  - Defined: the 32-bit retired-instruction counter is implemented as described.
  - Undefined: no counter register exists and `icount` is tied to 0.

## Test plan
- Reset, then `run`=1 and opcode=1 (add), MEM_LAT=1. The strobes must fire in order `ic_read`, `ir_ld`, `rf_read`, (EXEC), `rf_write`, `pc_incr`, with `wb_sel`=0. That is 6 cycles from IDLE exit to the next FETCH, and `icount`=1.
- opcode=5 (lw), MEM_LAT=3: `ic_read` is followed 3 cycles later by `ir_ld`. `dc_read` is followed 3 cycles later by `rf_write` with `wb_sel`=1. Total 11 cycles.
- opcode=8 (beq):
  - `beq_taken`=1 gives `pc_ld`=1 and `pc_incr`=0.
  - Next instruction with `beq_taken`=0 gives `pc_incr`=1.
  - `rf_write` never asserts in either case.
- opcode=63 gives `halted`=1 and `state`=8 two cycles after `ir_ld`. `illegal` stays 0, no further strobes for 20 cycles, and `icount` is unchanged.
- opcode=9 gives `illegal`=1 and `halted`=1. Asserting `rst` clears both within the same cycle, and `state` returns to 0.
- Drop `run` during EXEC of an add: `rf_write` and `pc_incr` still fire, then `state`=IDLE and stays there until `run` rises again.
